// File: rtl/shru_save_engine_if.sv
// Bundle for the shadow-register save engine: save request side, store stream to the
// data-cache store port, and the load-unit page-offset conflict query.
interface shru_save_engine_if #(
   parameter int XLEN   = 64,
   parameter int NrRegs = 4,
   parameter int LvlW   = 5
);
   logic                   save_i;
   logic [XLEN-1:0]        sp_i;
   logic [XLEN-1:0]        mepc_i;
   logic [XLEN-1:0]        mcause_i;
   logic [NrRegs*XLEN-1:0] regs_i;
   logic                   ready_o;
   logic [XLEN-1:0]        next_sp_o;
   logic [LvlW-1:0]        save_level_o;
   logic                   req_valid_o;
   logic [XLEN-1:0]        req_addr_o;
   logic [XLEN-1:0]        req_data_o;
   logic                   req_gnt_i;
   logic                   done_o;
   logic [11:0]            page_offset_i;
   logic                   page_offset_match_o;

   modport slave (
      input  save_i, sp_i, mepc_i, mcause_i, regs_i, req_gnt_i, page_offset_i,
      output ready_o, next_sp_o, save_level_o, req_valid_o, req_addr_o, req_data_o,
             done_o, page_offset_match_o
   );

   modport master (
      output save_i, sp_i, mepc_i, mcause_i, regs_i, req_gnt_i, page_offset_i,
      input  ready_o, next_sp_o, save_level_o, req_valid_o, req_addr_o, req_data_o,
             done_o, page_offset_match_o
   );
endinterface

// File: rtl/shru_save_engine.sv
// Nested interrupt-entry save engine: queues mepc/mcause/shadow-GPR frames below sp and
// streams them out one word per grant, flagging load page offsets that hit pending words.
module shru_save_engine #(
   parameter int XLEN      = 64,
   parameter int NrRegs    = 4,
   parameter int NestDepth = 4,
   parameter int LvlW      = 5
) (
   input logic               clk_i,
   input logic               rst_ni,
   shru_save_engine_if.slave bus
);
   localparam int NWORDS  = NrRegs + 2;
   localparam int WB      = XLEN / 8;
   localparam int FRAME_B = NWORDS * WB;
   localparam int PW      = $clog2(NestDepth);
   localparam int WCW     = $clog2(NWORDS);
   localparam int OL      = $clog2(WB);
   localparam int OW      = 12 - OL;

   logic [XLEN-1:0]   q_base [NestDepth];
   logic [XLEN-1:0]   q_data [NestDepth][NWORDS];
   logic [PW:0]       wr_ptr, rd_ptr, occ;
   logic [PW-1:0]     wr_idx, rd_idx;
   logic [WCW-1:0]    wcnt;
   logic              full, empty, accept, grant, last, pop, done_q;
   logic [XLEN-1:0]   frame_base;
   logic [NWORDS-1:0] head_keep;
   logic [NestDepth*NWORDS-1:0] pend;
   logic              unused_po;

   assign wr_idx     = wr_ptr[PW-1:0];
   assign rd_idx     = rd_ptr[PW-1:0];
   assign occ        = wr_ptr - rd_ptr;
   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);
   assign accept     = bus.save_i && !full;
   assign grant      = bus.req_gnt_i && !empty;
   assign last       = (wcnt == WCW'(NWORDS - 1));
   assign pop        = grant && last;
   assign frame_base = bus.sp_i - XLEN'(FRAME_B);

   assign bus.ready_o      = !full;
   assign bus.next_sp_o    = frame_base;
   assign bus.save_level_o = LvlW'(occ);
   assign bus.req_valid_o  = !empty;
   assign bus.req_addr_o   = empty ? '0 : q_base[rd_idx] + (XLEN'(wcnt) << OL);
   assign bus.req_data_o   = empty ? '0 : q_data[rd_idx][wcnt];
   assign bus.done_o       = done_q;

   // Frame payload needs no reset: it is only observed through occupied slots.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         q_base[wr_idx]    <= frame_base;
         q_data[wr_idx][0] <= bus.mepc_i;
         q_data[wr_idx][1] <= bus.mcause_i;
         for (int r = 0; r < NrRegs; r++) begin
            q_data[wr_idx][r+2] <= bus.regs_i[r*XLEN +: XLEN];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         wcnt   <= '0;
         done_q <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         if (grant)  wcnt   <= last ? '0 : wcnt + 1'b1;
         done_q <= pop;
      end
   end

   // Head-frame words at or above wcnt are still pending (thermometer mask).
   assign head_keep = ~((NWORDS'(1) << wcnt) - NWORDS'(1));

   for (genvar j = 0; j < NestDepth; j++) begin : g_slot
      logic [PW-1:0] rel;
      logic          live, head;
      assign rel  = PW'(j) - rd_idx;
      assign live = ({1'b0, rel} < occ);
      assign head = (rel == '0);
      for (genvar k = 0; k < NWORDS; k++) begin : g_word
         logic [OW-1:0] waddr;
         // k*WB has no bits below OL, so word index adds straight into the upper offset.
         assign waddr = q_base[j][11:OL] + OW'(k);
         assign pend[j*NWORDS+k] = live && (!head || head_keep[k]) &&
                                   (waddr == bus.page_offset_i[11:OL]);
      end
   end

   assign bus.page_offset_match_o = |pend;
   assign unused_po = ^bus.page_offset_i[OL-1:0];
endmodule

// File: tb/tb_shru_save_engine.sv
// Directed bench for shru_save_engine (XLEN=64, NrRegs=2, NestDepth=4): vector table for
// single-save and backpressure streams plus hand sequences for nesting, overlap and reset.
module tb_shru_save_engine;
   localparam int XLEN = 64;
   localparam int NR   = 2;
   localparam int ND   = 4;
   localparam int LW   = 5;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk = ~clk;

   shru_save_engine_if #(.XLEN(XLEN), .NrRegs(NR), .LvlW(LW)) bus ();

   shru_save_engine #(.XLEN(XLEN), .NrRegs(NR), .NestDepth(ND), .LvlW(LW)) dut (
      .clk_i (clk),
      .rst_ni(rst_ni),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_frame(input logic [63:0] sp, input logic [63:0] mepc,
                            input logic [63:0] mcause, input logic [63:0] r0,
                            input logic [63:0] r1);
      bus.sp_i     = sp;
      bus.mepc_i   = mepc;
      bus.mcause_i = mcause;
      bus.regs_i   = {r1, r0};
   endtask

   typedef struct {
      logic        save;
      logic        gnt;
      logic [11:0] po;
      logic        e_ready;
      logic [4:0]  e_level;
      logic        e_valid;
      logic [63:0] e_addr;
      logic [63:0] e_data;
      logic        e_done;
      logic        e_match;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic save, input logic gnt, input logic [11:0] po,
                               input logic rdy, input logic [4:0] lvl, input logic vld,
                               input logic [63:0] addr, input logic [63:0] data,
                               input logic done, input logic match);
      vec_t v;
      v.save = save; v.gnt = gnt; v.po = po; v.e_ready = rdy; v.e_level = lvl;
      v.e_valid = vld; v.e_addr = addr; v.e_data = data; v.e_done = done; v.e_match = match;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dones;
      logic [63:0] exp_d;

      // single save, continuous grant
      vecs.push_back(mk(1, 0, 12'h000, 1, 0, 0, 64'h0,   64'h0, 0, 0));
      vecs.push_back(mk(0, 1, 12'h000, 1, 1, 1, 64'hFE0, 64'hA, 0, 0));
      vecs.push_back(mk(0, 1, 12'hFE0, 1, 1, 1, 64'hFE8, 64'hB, 0, 0));
      vecs.push_back(mk(0, 1, 12'hFE8, 1, 1, 1, 64'hFF0, 64'hC, 0, 0));
      vecs.push_back(mk(0, 1, 12'hFF8, 1, 1, 1, 64'hFF8, 64'hD, 0, 1));
      vecs.push_back(mk(0, 1, 12'h000, 1, 0, 0, 64'h0,   64'h0, 1, 0));
      vecs.push_back(mk(0, 1, 12'h000, 1, 0, 0, 64'h0,   64'h0, 0, 0));
      // backpressure on word 1
      vecs.push_back(mk(1, 0, 12'h000, 1, 0, 0, 64'h0,   64'h0, 0, 0));
      vecs.push_back(mk(0, 1, 12'h000, 1, 1, 1, 64'hFE0, 64'hA, 0, 0));
      vecs.push_back(mk(0, 0, 12'h000, 1, 1, 1, 64'hFE8, 64'hB, 0, 0));
      vecs.push_back(mk(0, 0, 12'h000, 1, 1, 1, 64'hFE8, 64'hB, 0, 0));
      vecs.push_back(mk(0, 0, 12'h000, 1, 1, 1, 64'hFE8, 64'hB, 0, 0));
      vecs.push_back(mk(0, 1, 12'h000, 1, 1, 1, 64'hFE8, 64'hB, 0, 0));
      vecs.push_back(mk(0, 1, 12'hFF4, 1, 1, 1, 64'hFF0, 64'hC, 0, 1));
      vecs.push_back(mk(0, 1, 12'h000, 1, 1, 1, 64'hFF8, 64'hD, 0, 0));
      vecs.push_back(mk(0, 0, 12'hFF4, 1, 0, 0, 64'h0,   64'h0, 1, 0));

      // reset state
      bus.save_i = 1'b0;
      bus.req_gnt_i = 1'b0;
      bus.page_offset_i = 12'h0;
      set_frame(64'h1234, 64'h0, 64'h0, 64'h0, 64'h0);
      #2;
      check("rst next_sp", bus.next_sp_o, 64'h1214);
      check("rst ready", 64'(bus.ready_o), 64'h1);
      check("rst level", 64'(bus.save_level_o), 64'h0);
      check("rst valid", 64'(bus.req_valid_o), 64'h0);
      check("rst addr", bus.req_addr_o, 64'h0);
      check("rst data", bus.req_data_o, 64'h0);
      check("rst done", 64'(bus.done_o), 64'h0);
      check("rst match", 64'(bus.page_offset_match_o), 64'h0);
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;

      set_frame(64'h1000, 64'hA, 64'hB, 64'hC, 64'hD);
      #1;
      check("next_sp", bus.next_sp_o, 64'hFE0);

      foreach (vecs[i]) begin
         @(negedge clk);
         bus.save_i = vecs[i].save;
         bus.req_gnt_i = vecs[i].gnt;
         bus.page_offset_i = vecs[i].po;
         #1;
         check($sformatf("vec%0d ready", i), 64'(bus.ready_o), 64'(vecs[i].e_ready));
         check($sformatf("vec%0d level", i), 64'(bus.save_level_o), 64'(vecs[i].e_level));
         check($sformatf("vec%0d valid", i), 64'(bus.req_valid_o), 64'(vecs[i].e_valid));
         check($sformatf("vec%0d addr", i), bus.req_addr_o, vecs[i].e_addr);
         check($sformatf("vec%0d data", i), bus.req_data_o, vecs[i].e_data);
         check($sformatf("vec%0d done", i), 64'(bus.done_o), 64'(vecs[i].e_done));
         check($sformatf("vec%0d match", i), 64'(bus.page_offset_match_o), 64'(vecs[i].e_match));
      end

      // nesting to full: five back-to-back saves, fifth dropped
      bus.page_offset_i = 12'h0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         set_frame(64'h1000 * (i + 1), 64'h10 + i, 64'h20 + i, 64'h30 + i, 64'h40 + i);
         bus.save_i = 1'b1;
         bus.req_gnt_i = 1'b0;
         #1;
         check($sformatf("nest%0d ready", i), 64'(bus.ready_o), (i < 4) ? 64'h1 : 64'h0);
      end
      @(negedge clk);
      bus.save_i = 1'b0;
      bus.req_gnt_i = 1'b1;
      #1;
      check("nest level", 64'(bus.save_level_o), 64'h4);
      check("nest full ready", 64'(bus.ready_o), 64'h0);
      dones = 0;
      for (int f = 0; f < 4; f++) begin
         for (int k = 0; k < 4; k++) begin
            exp_d = 64'h10 * (k + 1) + f;
            check($sformatf("nest f%0d k%0d addr", f, k), bus.req_addr_o,
                  64'h1000 * (f + 1) - 64'h20 + 64'h8 * k);
            check($sformatf("nest f%0d k%0d data", f, k), bus.req_data_o, exp_d);
            if (bus.done_o) dones++;
            @(negedge clk);
            #1;
         end
      end
      if (bus.done_o) dones++;
      check("nest done count", 64'(dones), 64'h4);
      check("nest drained level", 64'(bus.save_level_o), 64'h0);
      check("nest drained valid", 64'(bus.req_valid_o), 64'h0);

      // save accepted in the same cycle the head frame pops
      @(negedge clk);
      bus.req_gnt_i = 1'b0;
      set_frame(64'h1000, 64'hA, 64'hB, 64'hC, 64'hD);
      bus.save_i = 1'b1;
      @(negedge clk);
      bus.save_i = 1'b0;
      bus.req_gnt_i = 1'b1;
      repeat (3) @(negedge clk);
      set_frame(64'h3000, 64'h77, 64'h78, 64'h79, 64'h7A);
      bus.save_i = 1'b1;
      #1;
      check("ovl last addr", bus.req_addr_o, 64'hFF8);
      check("ovl level before", 64'(bus.save_level_o), 64'h1);
      @(negedge clk);
      bus.save_i = 1'b0;
      bus.req_gnt_i = 1'b0;
      #1;
      check("ovl level after", 64'(bus.save_level_o), 64'h1);
      check("ovl done", 64'(bus.done_o), 64'h1);
      check("ovl new addr", bus.req_addr_o, 64'h2FE0);
      check("ovl new data", bus.req_data_o, 64'h77);
      @(negedge clk);
      bus.req_gnt_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("ovl k%0d addr", k), bus.req_addr_o, 64'h2FE0 + 64'h8 * k);
         check($sformatf("ovl k%0d data", k), bus.req_data_o, 64'h77 + k);
         @(negedge clk);
      end
      #1;
      check("ovl final level", 64'(bus.save_level_o), 64'h0);
      check("ovl final done", 64'(bus.done_o), 64'h1);

      // reset mid-stream after two grants
      @(negedge clk);
      bus.req_gnt_i = 1'b0;
      set_frame(64'h1000, 64'hA, 64'hB, 64'hC, 64'hD);
      bus.save_i = 1'b1;
      @(negedge clk);
      bus.save_i = 1'b0;
      bus.req_gnt_i = 1'b1;
      repeat (2) @(negedge clk);
      bus.req_gnt_i = 1'b0;
      bus.page_offset_i = 12'hFF0;
      #1;
      check("mid addr", bus.req_addr_o, 64'hFF0);
      check("mid match", 64'(bus.page_offset_match_o), 64'h1);
      #1;
      rst_ni = 1'b0;
      #1;
      check("async rst ready", 64'(bus.ready_o), 64'h1);
      check("async rst level", 64'(bus.save_level_o), 64'h0);
      check("async rst valid", 64'(bus.req_valid_o), 64'h0);
      check("async rst addr", bus.req_addr_o, 64'h0);
      check("async rst data", bus.req_data_o, 64'h0);
      check("async rst done", 64'(bus.done_o), 64'h0);
      check("async rst match", 64'(bus.page_offset_match_o), 64'h0);
      check("async rst next_sp", bus.next_sp_o, 64'hFE0);
      @(negedge clk);
      rst_ni = 1'b1;
      bus.req_gnt_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         check($sformatf("post rst c%0d valid", c), 64'(bus.req_valid_o), 64'h0);
         check($sformatf("post rst c%0d level", c), 64'(bus.save_level_o), 64'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
